// File: rtl/gamma_frame_gate.sv
// gamma_frame_gate
//   Frame gate for a packed 10-bit RGB AXI4-Stream video input. It
//   truncates each 10-bit channel to 8 bits with no added latency and
//   only forwards frames that begin with a start-of-frame (tuser) beat.
//   Line length and early-SOF errors are detected while a frame is in
//   flight. A frame with a length error is dropped for the rest of its
//   beats. A frame with an early SOF is restarted at the offending beat.
//
// Parameters
//   H_PIX    active pixels per line (beats between tlast)
//   V_LINES  active lines per frame
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   enable               1 = gate frames through, 0 = discard input
//   single               1 = forward one good frame, then go idle
//   clr_err              pulse, clears the sticky error flags
//   s_axis_video_*       32-bit packed 10-bit RGB input stream
//   m_axis_video_*       24-bit 8-bit RGB output stream
//   busy                 FSM is in WAIT_SOF, PASS or DROP
//   frame_done           high on the accepted last beat of a good frame
//   err_len, err_sof     sticky line-length / early-SOF error flags
//   frames_ok/drop       saturating good / dropped frame counters
module gamma_frame_gate #(
    parameter int H_PIX   = 1280,
    parameter int V_LINES = 720
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        single,
    input  logic        clr_err,
    input  logic [31:0] s_axis_video_tdata,
    input  logic        s_axis_video_tvalid,
    input  logic        s_axis_video_tuser,
    input  logic        s_axis_video_tlast,
    output logic        s_axis_video_tready,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    input  logic        m_axis_video_tready,
    output logic        busy,
    output logic        frame_done,
    output logic        err_len,
    output logic        err_sof,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_drop
);

    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, PASS, DROP} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          shot_done;
    logic          hunting;
    logic          beat;
    logic          len_bad;
    logic          sof_bad;
    logic [XW-1:0] start_x;
    logic [YW-1:0] start_y;
    logic          unused_lsbs;

    // Drop the two LSBs of each 10-bit channel.
    assign m_axis_video_tdata = {s_axis_video_tdata[29:22],
                                 s_axis_video_tdata[19:12],
                                 s_axis_video_tdata[9:2]};
    assign unused_lsbs = ^{s_axis_video_tdata[31:30], s_axis_video_tdata[21:20],
                           s_axis_video_tdata[11:10], s_axis_video_tdata[1:0]};

    assign hunting = (state == WAIT_SOF) || (state == DROP);

    // Outside PASS, only an SOF beat seen while hunting is offered downstream.
    // Every other input beat is swallowed with tready held high.
    always_comb begin
        s_axis_video_tready = 1'b1;
        m_axis_video_tvalid = 1'b0;
        if (state == PASS) begin
            m_axis_video_tvalid = s_axis_video_tvalid;
            s_axis_video_tready = m_axis_video_tready;
        end else if (hunting && s_axis_video_tvalid && s_axis_video_tuser) begin
            m_axis_video_tvalid = 1'b1;
            s_axis_video_tready = m_axis_video_tready;
        end
    end

    assign m_axis_video_tuser = m_axis_video_tvalid & s_axis_video_tuser;
    assign m_axis_video_tlast = m_axis_video_tvalid & s_axis_video_tlast;
    assign beat               = s_axis_video_tvalid & s_axis_video_tready;

    assign len_bad = s_axis_video_tlast ? (x != X_LAST) : (x == X_LAST);
    assign sof_bad = s_axis_video_tuser && ((x != '0) || (y != '0));

    // An SOF beat is pixel 0. The next pixel is x=1, unless the beat already
    // closes a one-pixel line.
    always_comb begin
        start_x = XW'(1);
        start_y = '0;
        if (H_PIX == 1 && s_axis_video_tlast) begin
            start_x = '0;
            start_y = YW'(1);
        end
    end

    // frame_done marks the completing handshake itself, so it is decoded
    // from the live beat rather than registered a cycle late. A length error
    // and then an early SOF on the same beat both take precedence over
    // completion.
    assign frame_done = (state == PASS) && beat && !len_bad && !sof_bad &&
                        s_axis_video_tlast && (y == Y_LAST);
    assign busy = (state != IDLE);

    // Main FSM, position counters, sticky errors and frame counters.
    // shot_done keeps a single-shot capture from re-arming while enable and
    // single stay high. It clears once either input is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            shot_done   <= 1'b0;
            err_len     <= 1'b0;
            err_sof     <= 1'b0;
            frames_ok   <= '0;
            frames_drop <= '0;
        end else begin
            if (clr_err) begin
                err_len <= 1'b0;
                err_sof <= 1'b0;
            end
            if (!enable || !single) begin
                shot_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable && !shot_done) begin
                        state <= WAIT_SOF;
                    end
                end
                WAIT_SOF, DROP: begin
                    if (beat && s_axis_video_tuser) begin
                        state <= PASS;
                        x     <= start_x;
                        y     <= start_y;
                    end else if (!enable) begin
                        state <= IDLE;
                    end
                end
                PASS: begin
                    if (beat) begin
                        if (len_bad) begin
                            err_len <= 1'b1;
                            if (frames_drop != 16'hFFFF) frames_drop <= frames_drop + 16'd1;
                            state <= DROP;
                            x     <= '0;
                            y     <= '0;
                        end else if (sof_bad) begin
                            err_sof <= 1'b1;
                            if (frames_drop != 16'hFFFF) frames_drop <= frames_drop + 16'd1;
                            x <= start_x;
                            y <= start_y;
                        end else if (s_axis_video_tlast) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                y <= '0;
                                if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
                                if (single) shot_done <= 1'b1;
                                state <= (!enable || single) ? IDLE : WAIT_SOF;
                            end else begin
                                y <= y + YW'(1);
                            end
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gamma_frame_gate.sv
// tb_gamma_frame_gate
//   Drives the frame gate with H_PIX=4, V_LINES=3. The stimulus streams have
//   random data, random valid gaps and random output backpressure. The
//   expected output is built by a frame-position reference model kept in
//   this module. The model tracks one flat pixel index per frame.
module tb_gamma_frame_gate;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int FL = H * V;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        single;
    logic        clr_err;
    logic [31:0] s_axis_video_tdata;
    logic        s_axis_video_tvalid;
    logic        s_axis_video_tuser;
    logic        s_axis_video_tlast;
    logic        s_axis_video_tready;
    logic [23:0] m_axis_video_tdata;
    logic        m_axis_video_tvalid;
    logic        m_axis_video_tuser;
    logic        m_axis_video_tlast;
    logic        m_axis_video_tready;
    logic        busy;
    logic        frame_done;
    logic        err_len;
    logic        err_sof;
    logic [15:0] frames_ok;
    logic [15:0] frames_drop;

    always #5 clk = ~clk;

    gamma_frame_gate #(.H_PIX(H), .V_LINES(V)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .enable              (enable),
        .single              (single),
        .clr_err             (clr_err),
        .s_axis_video_tdata  (s_axis_video_tdata),
        .s_axis_video_tvalid (s_axis_video_tvalid),
        .s_axis_video_tuser  (s_axis_video_tuser),
        .s_axis_video_tlast  (s_axis_video_tlast),
        .s_axis_video_tready (s_axis_video_tready),
        .m_axis_video_tdata  (m_axis_video_tdata),
        .m_axis_video_tvalid (m_axis_video_tvalid),
        .m_axis_video_tuser  (m_axis_video_tuser),
        .m_axis_video_tlast  (m_axis_video_tlast),
        .m_axis_video_tready (m_axis_video_tready),
        .busy                (busy),
        .frame_done          (frame_done),
        .err_len             (err_len),
        .err_sof             (err_sof),
        .frames_ok           (frames_ok),
        .frames_drop         (frames_drop)
    );

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
    } in_beat_t;

    typedef struct {
        logic [23:0] data;
        logic        user;
        logic        last;
        logic        done;
    } out_beat_t;

    in_beat_t  stim_q[$];
    out_beat_t got_q[$];
    out_beat_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int timeouts = 0;

    // Reference model state: mode 0 = idle, 1 = hunting for SOF, 2 = in frame
    int   m_mode;
    int   m_pos;
    int   exp_ok;
    int   exp_drop;
    logic exp_err_len;
    logic exp_err_sof;

    // Record every output handshake. Signals are stable at the falling edge.
    always @(negedge clk) begin : monitor
        out_beat_t ob;
        if (rstn && m_axis_video_tvalid && m_axis_video_tready) begin
            ob.data = m_axis_video_tdata;
            ob.user = m_axis_video_tuser;
            ob.last = m_axis_video_tlast;
            ob.done = frame_done;
            got_q.push_back(ob);
        end
    end

    // 10-bit to 8-bit per channel: each channel value divided by 4.
    function automatic logic [23:0] to8(input logic [31:0] d);
        int r, g, b;
        r = int'((d >> 20) & 32'h3FF) / 4;
        g = int'((d >> 10) & 32'h3FF) / 4;
        b = int'(d & 32'h3FF) / 4;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic model_beat(input in_beat_t b, input bit single_mode);
        out_beat_t o;
        o.data = to8(b.data);
        o.user = b.user;
        o.last = b.last;
        o.done = 1'b0;
        if (m_mode == 0) return;
        if (m_mode == 1) begin
            if (!b.user) return;
            exp_q.push_back(o);
            m_mode = 2;
            m_pos  = 1;
            return;
        end
        if (b.last != ((m_pos % H) == H - 1)) begin
            exp_err_len = 1'b1;
            if (exp_drop < 65535) exp_drop++;
            m_mode = 1;
        end else if (b.user) begin
            exp_err_sof = 1'b1;
            if (exp_drop < 65535) exp_drop++;
            m_pos = 1;
        end else begin
            m_pos++;
            if (m_pos == FL) begin
                o.done = 1'b1;
                if (exp_ok < 65535) exp_ok++;
                m_mode = single_mode ? 0 : 1;
                m_pos  = 0;
            end
        end
        exp_q.push_back(o);
    endtask

    task automatic model_stream(input bit single_mode);
        foreach (stim_q[i]) model_beat(stim_q[i], single_mode);
    endtask

    function automatic int stream_diffs();
        int d;
        d = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                          : exp_q.size() - got_q.size();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i].data !== exp_q[i].data || got_q[i].user !== exp_q[i].user ||
                got_q[i].last !== exp_q[i].last || got_q[i].done !== exp_q[i].done) d++;
        end
        return d;
    endfunction

    task automatic add_beat(input logic user, input logic last, input logic [31:0] d);
        in_beat_t b;
        b.data = d;
        b.user = user;
        b.last = last;
        stim_q.push_back(b);
    endtask

    // n beats of a frame with SOF on beat 0. Line ends fall every H beats,
    // plus an extra tlast at early_last when that index is non-negative.
    task automatic add_frame(input int n, input int early_last);
        for (int i = 0; i < n; i++)
            add_beat(i == 0, ((i % H) == H - 1) || (i == early_last), $urandom);
    endtask

    task automatic add_junk(input int n);
        for (int i = 0; i < n; i++) add_beat(1'b0, (i % H) == H - 1, $urandom);
    endtask

    // rmode: 0 ready high, 1 random, 2 toggling, 3 ready low.
    // gap_pct is the chance of an idle input cycle.
    task automatic send_stream(input int rmode, input int gap_pct);
        for (int i = 0; i < stim_q.size(); i++) begin
            int waited = 0;
            bit taken  = 0;
            bit first  = 1;
            while (!taken) begin
                @(posedge clk);
                #1;
                if (first || !s_axis_video_tvalid)
                    s_axis_video_tvalid = (int'($urandom_range(99)) >= gap_pct);
                first = 0;
                s_axis_video_tdata = stim_q[i].data;
                s_axis_video_tuser = stim_q[i].user;
                s_axis_video_tlast = stim_q[i].last;
                case (rmode)
                    0:       m_axis_video_tready = 1'b1;
                    1:       m_axis_video_tready = 1'($urandom_range(1));
                    2:       m_axis_video_tready = ~m_axis_video_tready;
                    default: m_axis_video_tready = 1'b0;
                endcase
                @(negedge clk);
                if (s_axis_video_tvalid && s_axis_video_tready) begin
                    taken = 1;
                end else begin
                    waited++;
                    if (waited > 100) begin
                        timeouts++;
                        s_axis_video_tvalid = 1'b0;
                        return;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        s_axis_video_tvalid = 1'b0;
        m_axis_video_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_and_arm(input logic single_v);
        rstn = 1'b0;
        enable = 1'b0;
        single = single_v;
        clr_err = 1'b0;
        s_axis_video_tvalid = 1'b0;
        s_axis_video_tuser = 1'b0;
        s_axis_video_tlast = 1'b0;
        s_axis_video_tdata = '0;
        m_axis_video_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        got_q.delete();
        exp_q.delete();
        stim_q.delete();
        timeouts = 0;
        m_mode = 1;
        m_pos = 0;
        exp_ok = 0;
        exp_drop = 0;
        exp_err_len = 1'b0;
        exp_err_sof = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        enable = 1'b1; single = 1'b0; clr_err = 1'b1; m_axis_video_tready = 1'b1;
        s_axis_video_tvalid = 1'b1; s_axis_video_tuser = 1'b1; s_axis_video_tlast = 1'b1;
        s_axis_video_tdata = $urandom;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("[TB] FAIL rst_done: got %b want 0", frame_done); else n_pass++;
        n_checks++; if (err_len !== 1'b0 || err_sof !== 1'b0) $display("[TB] FAIL rst_err: got %b%b want 00", err_len, err_sof); else n_pass++;
        n_checks++; if (frames_ok !== 16'd0) $display("[TB] FAIL rst_ok: got %0d want 0", frames_ok); else n_pass++;
        n_checks++; if (frames_drop !== 16'd0) $display("[TB] FAIL rst_drop: got %0d want 0", frames_drop); else n_pass++;
        n_checks++; if (m_axis_video_tvalid !== 1'b0) $display("[TB] FAIL rst_mvalid: got %b want 0", m_axis_video_tvalid); else n_pass++;
        n_checks++; if (s_axis_video_tready !== 1'b1) $display("[TB] FAIL rst_sready: got %b want 1", s_axis_video_tready); else n_pass++;
        s_axis_video_tvalid = 1'b0; s_axis_video_tuser = 1'b0; s_axis_video_tlast = 1'b0; clr_err = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL arm_busy: got %b want 1", busy); else n_pass++;
    endtask

    task automatic test_good_frame();
        int dn = 0;
        reset_and_arm(1'b0);
        add_frame(FL, -1);
        stim_q[0].data = 32'h3FF003FF;
        send_stream(0, 0);
        model_stream(1'b0);
        foreach (got_q[i]) dn += int'(got_q[i].done);
        n_checks++; if (got_q.size() !== 12) $display("[TB] FAIL good_count: got %0d want 12", got_q.size()); else n_pass++;
        n_checks++; if (got_q.size() == 0 || got_q[0].data !== 24'hFF00FF) $display("[TB] FAIL good_map: first beat wrong or missing, want ff00ff"); else n_pass++;
        n_checks++; if (stream_diffs() !== 0) $display("[TB] FAIL good_stream: %0d diffs want 0", stream_diffs()); else n_pass++;
        n_checks++; if (dn !== 1) $display("[TB] FAIL good_done: %0d pulses want 1", dn); else n_pass++;
        n_checks++; if (frames_ok !== 16'd1) $display("[TB] FAIL good_ok: got %0d want 1", frames_ok); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL good_rearm: busy %b want 1", busy); else n_pass++;
        n_checks++; if (timeouts !== 0) $display("[TB] FAIL good_timeout: got %0d want 0", timeouts); else n_pass++;
    endtask

    task automatic test_junk_then_sof();
        reset_and_arm(1'b0);
        add_junk(7);
        send_stream(3, 0);
        model_stream(1'b0);
        n_checks++; if (timeouts !== 0) $display("[TB] FAIL junk_absorb: %0d stalls want 0", timeouts); else n_pass++;
        n_checks++; if (got_q.size() !== 0) $display("[TB] FAIL junk_leak: got %0d beats want 0", got_q.size()); else n_pass++;
        stim_q.delete();
        add_frame(FL, -1);
        send_stream(1, 25);
        model_stream(1'b0);
        n_checks++; if (got_q.size() == 0 || got_q[0].user !== 1'b1) $display("[TB] FAIL junk_first_user: first beat lacks tuser"); else n_pass++;
        n_checks++; if (stream_diffs() !== 0) $display("[TB] FAIL junk_stream: %0d diffs want 0", stream_diffs()); else n_pass++;
        n_checks++; if (frames_ok !== 16'(exp_ok)) $display("[TB] FAIL junk_ok: got %0d want %0d", frames_ok, exp_ok); else n_pass++;
    endtask

    task automatic test_len_err();
        reset_and_arm(1'b0);
        add_frame(3, 2);
        add_junk(9);
        add_frame(FL, -1);
        send_stream(1, 20);
        model_stream(1'b0);
        n_checks++; if (err_len !== 1'b1) $display("[TB] FAIL len_flag: got %b want 1", err_len); else n_pass++;
        n_checks++; if (err_sof !== 1'b0) $display("[TB] FAIL len_sof: got %b want 0", err_sof); else n_pass++;
        n_checks++; if (frames_drop !== 16'd1) $display("[TB] FAIL len_drop: got %0d want 1", frames_drop); else n_pass++;
        n_checks++; if (frames_ok !== 16'd1) $display("[TB] FAIL len_ok: got %0d want 1", frames_ok); else n_pass++;
        n_checks++; if (got_q.size() !== 15 || stream_diffs() !== 0) $display("[TB] FAIL len_stream: %0d beats, %0d diffs, want 15/0", got_q.size(), stream_diffs()); else n_pass++;
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        n_checks++; if (err_len !== 1'b0) $display("[TB] FAIL len_clear: got %b want 0", err_len); else n_pass++;
    endtask

    task automatic test_sof_err();
        reset_and_arm(1'b0);
        add_frame(5, -1);
        add_frame(FL, -1);
        send_stream(1, 20);
        model_stream(1'b0);
        n_checks++; if (err_sof !== 1'b1) $display("[TB] FAIL sof_flag: got %b want 1", err_sof); else n_pass++;
        n_checks++; if (err_len !== 1'b0) $display("[TB] FAIL sof_len: got %b want 0", err_len); else n_pass++;
        n_checks++; if (frames_drop !== 16'd1 || frames_ok !== 16'd1) $display("[TB] FAIL sof_counts: ok %0d drop %0d want 1/1", frames_ok, frames_drop); else n_pass++;
        n_checks++; if (got_q.size() !== 17 || stream_diffs() !== 0) $display("[TB] FAIL sof_stream: %0d beats, %0d diffs, want 17/0", got_q.size(), stream_diffs()); else n_pass++;
    endtask

    task automatic test_single();
        reset_and_arm(1'b1);
        add_frame(FL, -1);
        add_frame(FL, -1);
        add_frame(FL, -1);
        send_stream(2, 0);
        model_stream(1'b1);
        n_checks++; if (frames_ok !== 16'd1) $display("[TB] FAIL single_ok: got %0d want 1", frames_ok); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL single_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (got_q.size() !== 12 || stream_diffs() !== 0) $display("[TB] FAIL single_stream: %0d beats, %0d diffs, want 12/0", got_q.size(), stream_diffs()); else n_pass++;
        n_checks++; if (frames_drop !== 16'd0) $display("[TB] FAIL single_drop: got %0d want 0", frames_drop); else n_pass++;
    endtask

    task automatic test_reset_mid();
        in_beat_t rest[$];
        reset_and_arm(1'b0);
        add_frame(FL, -1);
        rest = stim_q[6:$];
        stim_q = stim_q[0:5];
        send_stream(0, 0);
        n_checks++; if (got_q.size() !== 6) $display("[TB] FAIL mid_pre: got %0d beats want 6", got_q.size()); else n_pass++;
        @(posedge clk);
        #1;
        s_axis_video_tvalid = 1'b1;
        s_axis_video_tdata = rest[0].data;
        s_axis_video_tuser = rest[0].user;
        s_axis_video_tlast = rest[0].last;
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || m_axis_video_tvalid !== 1'b0) $display("[TB] FAIL mid_state: busy %b mvalid %b want 0/0", busy, m_axis_video_tvalid); else n_pass++;
        n_checks++; if (frames_ok !== 16'd0 || frames_drop !== 16'd0 || frame_done !== 1'b0) $display("[TB] FAIL mid_counts: ok %0d drop %0d done %b want 0", frames_ok, frames_drop, frame_done); else n_pass++;
        s_axis_video_tvalid = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        got_q.delete();
        exp_q.delete();
        m_mode = 1;
        m_pos = 0;
        repeat (2) @(posedge clk);
        #1;
        stim_q = rest;
        add_frame(FL, -1);
        send_stream(1, 20);
        model_stream(1'b0);
        n_checks++; if (frames_ok !== 16'd1 || frames_drop !== 16'd0) $display("[TB] FAIL mid_after: ok %0d drop %0d want 1/0", frames_ok, frames_drop); else n_pass++;
        n_checks++; if (got_q.size() !== 12 || stream_diffs() !== 0) $display("[TB] FAIL mid_stream: %0d beats, %0d diffs, want 12/0", got_q.size(), stream_diffs()); else n_pass++;
    endtask

    task automatic test_random();
        reset_and_arm(1'b0);
        for (int k = 0; k < 30; k++) begin
            int el;
            case ($urandom_range(4))
                0, 1: add_frame(FL, -1);
                2: begin
                    el = int'($urandom_range(FL - 1));
                    add_frame(el + 1, el);
                end
                3: add_frame(int'($urandom_range(1, FL - 1)), -1);
                default: begin
                    for (int j = 0; j < int'($urandom_range(1, 6)); j++)
                        add_beat($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom);
                end
            endcase
        end
        send_stream(1, 30);
        model_stream(1'b0);
        n_checks++; if (timeouts !== 0) $display("[TB] FAIL rand_timeout: got %0d want 0", timeouts); else n_pass++;
        n_checks++; if (stream_diffs() !== 0) $display("[TB] FAIL rand_stream: %0d diffs (got %0d beats, want %0d)", stream_diffs(), got_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (frames_ok !== 16'(exp_ok)) $display("[TB] FAIL rand_ok: got %0d want %0d", frames_ok, exp_ok); else n_pass++;
        n_checks++; if (frames_drop !== 16'(exp_drop)) $display("[TB] FAIL rand_drop: got %0d want %0d", frames_drop, exp_drop); else n_pass++;
        n_checks++; if (err_len !== exp_err_len || err_sof !== exp_err_sof) $display("[TB] FAIL rand_err: got %b%b want %b%b", err_len, err_sof, exp_err_len, exp_err_sof); else n_pass++;
    endtask

    initial begin
        rstn = 1'b1;
        enable = 1'b0;
        single = 1'b0;
        clr_err = 1'b0;
        s_axis_video_tdata = '0;
        s_axis_video_tvalid = 1'b0;
        s_axis_video_tuser = 1'b0;
        s_axis_video_tlast = 1'b0;
        m_axis_video_tready = 1'b1;
        #2 rstn = 1'b0;
        test_reset();
        test_good_frame();
        test_junk_then_sof();
        test_len_err();
        test_sof_err();
        test_single();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
